// File: rtl/puf_challenge_ctrl.sv
// Ring-oscillator PUF challenge sequencer with response capture and compare.
// Define PUF_MAJORITY_EN for three-vote majority per response bit.
module puf_challenge_ctrl #(
  parameter int RESP_BITS     = 8,
  parameter int SETTLE_CYCLES = 64,
  parameter int EVAL_CYCLES   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RESP_BITS-1:0] expected,
  output logic                 puf_enable,
  output logic [1:0]           puf_challenge,
  input  logic                 puf_response,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 match,
  output logic                 unstable
);
  localparam int IW = $clog2(RESP_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_EVAL   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [15:0]   SET_LD   = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0]   EVL_LD   = 16'(EVAL_CYCLES - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(RESP_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [IW-1:0]        bit_q, bit_d, bit_nx;
  logic [RESP_BITS-1:0] exp_q, exp_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [1:0]           chal_q, chal_d, chal_nx;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 match_q, match_d;
  logic                 unst_q, unst_d;
  logic [1:0]           sync_q;
  logic                 smp, last_vote, bit_val, split;

  assign smp    = sync_q[1];
  assign bit_nx = bit_q + IW'(1);

  // Challenge is the low two bits of the bit index, so it wraps every 4 bits.
  if (IW >= 2) begin : g_chal
    assign chal_nx = bit_nx[1:0];
  end else begin : g_chal1
    assign chal_nx = {1'b0, bit_nx};
  end

`ifdef PUF_MAJORITY_EN
  logic [1:0] v_q;
  logic [1:0] votes_q;

  assign last_vote = (v_q == 2'd2);
  assign bit_val   = (votes_q[0] & votes_q[1]) |
                     (votes_q[0] & smp) |
                     (votes_q[1] & smp);
  assign split     = !((votes_q[0] == votes_q[1]) &&
                       (votes_q[1] == smp));

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      votes_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      v_q <= '0;
    end else if (state_q == S_SAMPLE) begin
      if (last_vote) begin
        v_q <= '0;
      end else begin
        v_q              <= v_q + 2'd1;
        votes_q[v_q[0]]  <= smp;
      end
    end
  end
`else
  assign last_vote = 1'b1;
  assign bit_val   = smp;
  assign split     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    exp_d   = exp_q;
    resp_d  = resp_q;
    chal_d  = chal_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;
    unst_d  = unst_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          cnt_d   = SET_LD;
          bit_d   = '0;
          exp_d   = expected;
          resp_d  = '0;
          match_d = 1'b0;
          unst_d  = 1'b0;
          chal_d  = 2'd0;
          en_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == '0) begin
          state_d = S_EVAL;
          cnt_d   = EVL_LD;
          en_d    = 1'b1;
        end
      end
      S_EVAL: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end
      end
      S_SAMPLE: begin
        state_d = S_SETTLE;
        cnt_d   = SET_LD;
        en_d    = 1'b0;
        if (last_vote) begin
          for (int j = 0; j < RESP_BITS; j++) begin
            if (bit_q == IW'(j)) resp_d[j] = bit_val;
          end
          unst_d = unst_q | split;
          if (bit_q == LAST_BIT) begin
            state_d = S_DONE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (resp_d == exp_q);
          end else begin
            bit_d  = bit_nx;
            chal_d = chal_nx;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      exp_q   <= '0;
      resp_q  <= '0;
      chal_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      unst_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      exp_q   <= exp_d;
      resp_q  <= resp_d;
      chal_q  <= chal_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      unst_q  <= unst_d;
      sync_q  <= {sync_q[0], puf_response};
    end
  end

  assign puf_enable    = en_q;
  assign puf_challenge = chal_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign response      = resp_q;
  assign match         = match_q;
  assign unstable      = unst_q;
endmodule
